// File: rtl/regfile_mp_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Holds the sweep/run state enum used by the register file controller.
package regfile_mp_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage : regfile_mp_pkg

// File: rtl/regfile_sb.sv
// Busy-bit scoreboard: one pending-producer flag per architectural register.
// Register 0 is never busy; a set beats a same-cycle write-clear.
module regfile_sb #(
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  parameter  int NWR   = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    busy_d = busy_q;
    if (clr) begin
      busy_d = '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j]) busy_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
      if (set_en) busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Only registered state is visible; same-cycle set/clear is not forwarded.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign rd_busy[i] = busy_q[rd_addr[i*AW +: AW]];
  end

endmodule : regfile_sb

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero, optional write-to-read
// bypass, busy scoreboard, and a one-register-per-cycle clearing sweep.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEFAULT,
  parameter  int NREGS  = NREGS_DEFAULT,
  parameter  int NRD    = 2,
  parameter  int NWR    = 1,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  input  logic                clr_req,
  output logic                ready
);

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] mem [NREGS];

  logic [AW-1:0]   wa [NWR];
  logic [XLEN-1:0] wd [NWR];
  logic [NWR-1:0]  wr_go;

  assign ready = (state_q == RUN);

  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign wa[j]    = wr_addr[j*AW +: AW];
    assign wd[j]    = wr_data[j*XLEN +: XLEN];
    assign wr_go[j] = wr_en[j] & ready & (wa[j] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      SWEEP: begin
        if (idx_q == AW'(NREGS - 1)) state_d = RUN;
        else                         idx_d   = idx_q + AW'(1);
      end
      RUN: begin
        if (clr_req) begin
          state_d = SWEEP;
          idx_d   = AW'(1);
        end
      end
      default: begin
        state_d = SWEEP;
        idx_d   = AW'(1);
      end
    endcase
  end

  // NOTE: storage has no reset; the post-reset sweep zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[idx_q] <= '0;
    end else begin
      // Later ports are assigned last, so port 1 wins an address collision.
      for (int j = 0; j < NWR; j++) begin
        if (wr_go[j]) mem[wa[j]] <= wd[j];
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] val;

    assign ra = rd_addr[i*AW +: AW];

    always_comb begin
      val = mem[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_go[j] && (wa[j] == ra)) val = wd[j];
        end
      end
      if (ra == '0) val = '0;
    end

    assign rd_data[i*XLEN +: XLEN] = val;
  end

  regfile_sb #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ready & clr_req),
    .set_en   (ready & sb_set),
    .set_addr (sb_addr),
    .wr_en    (wr_go),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp; a BYPASS=1 and a BYPASS=0
// instance share stimulus and are checked against an array-based model.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = $clog2(NREGS);

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data, rd_data_nb;
  logic [NRD-1:0]      rd_busy, rd_busy_nb;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic                clr_req;
  logic                ready, ready_nb;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural contents, known-ness, busy flags, sweep progress.
  logic [XLEN-1:0] m_mem   [NREGS];
  bit              m_valid [NREGS];
  bit              m_busy  [NREGS];
  bit              m_sweeping;
  int              m_pos;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set),
    .sb_addr(sb_addr), .clr_req(clr_req), .ready(ready)
  );

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set),
    .sb_addr(sb_addr), .clr_req(clr_req), .ready(ready_nb)
  );

  task automatic model_reset();
    m_sweeping = 1'b1;
    m_pos      = 1;
    for (int a = 0; a < NREGS; a++) m_busy[a] = 1'b0;
  endtask

  // Applies the architectural effect of one clock edge using the inputs now on the pins.
  task automatic model_edge();
    if (m_sweeping) begin
      m_mem[m_pos]   = '0;
      m_valid[m_pos] = 1'b1;
      if (m_pos == NREGS - 1) m_sweeping = 1'b0;
      else                    m_pos++;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        int a;
        a = int'(wr_addr[j*AW +: AW]);
        if (wr_en[j] && a != 0) begin
          m_mem[a]   = wr_data[j*XLEN +: XLEN];
          m_valid[a] = 1'b1;
        end
      end
      if (clr_req) begin
        for (int a = 0; a < NREGS; a++) m_busy[a] = 1'b0;
        m_sweeping = 1'b1;
        m_pos      = 1;
      end else begin
        for (int j = 0; j < NWR; j++)
          if (wr_en[j]) m_busy[int'(wr_addr[j*AW +: AW])] = 1'b0;
        if (sb_set && sb_addr != '0) m_busy[int'(sb_addr)] = 1'b1;
      end
    end
  endtask

  // Expected read value; returns 0 when the model does not know the stored contents.
  function automatic bit exp_read(input int a, input bit byp, output logic [XLEN-1:0] v);
    v = '0;
    if (a == 0) return 1'b1;
    if (byp && !m_sweeping) begin
      for (int j = NWR - 1; j >= 0; j--) begin
        if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
          v = wr_data[j*XLEN +: XLEN];
          return 1'b1;
        end
      end
    end
    v = m_mem[a];
    return m_valid[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    sb_set  = 1'b0;
    sb_addr = '0;
    clr_req = 1'b0;
  endtask

  task automatic drive_wr(input int port, input int addr, input logic [XLEN-1:0] data);
    wr_en[port]               = 1'b1;
    wr_addr[port*AW +: AW]    = AW'(addr);
    wr_data[port*XLEN +: XLEN] = data;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr[0 +: AW]  = AW'(a0);
    rd_addr[AW +: AW] = AW'(a1);
  endtask

  // Counts edges until ready rises; optionally throws random requests at the sweep.
  task automatic wait_sweep(input bit noise, output int cnt);
    cnt = 0;
    while (!ready && cnt < 200) begin
      if (noise) begin
        wr_en   = NWR'($urandom);
        wr_addr = (NWR*AW)'($urandom);
        wr_data = {$urandom, $urandom};
        sb_set  = 1'(($urandom));
        sb_addr = AW'($urandom);
        clr_req = 1'(($urandom));
      end
      tick();
      cnt++;
    end
    idle();
  endtask

  task automatic test_reset();
    int cnt;
    idle();
    set_rd(0, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready: got %b want 0", ready);
    end
    n_cmp++;
    if (rd_busy !== '0) begin
      n_bad++; $display("FAIL reset_busy: got %b want 0", rd_busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sweep(1'b0, cnt);
    n_cmp++;
    if (cnt != NREGS - 1 || m_sweeping) begin
      n_bad++; $display("FAIL reset_sweep_len: got %0d cycles want %0d", cnt, NREGS - 1);
    end
    for (int a = 0; a < NREGS; a += 2) begin
      set_rd(a, a + 1);
      #1;
      for (int p = 0; p < NRD; p++) begin
        n_cmp++;
        if (rd_data[p*XLEN +: XLEN] !== '0 || rd_data_nb[p*XLEN +: XLEN] !== '0 || rd_busy[p] !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_zero x%0d: got %h/%h busy %b want 0/0 busy 0",
                   a + p, rd_data[p*XLEN +: XLEN], rd_data_nb[p*XLEN +: XLEN], rd_busy[p]);
        end
      end
    end
  endtask

  task automatic test_write_bypass();
    logic [XLEN-1:0] v;
    bit              k;
    idle();
    drive_wr(0, 5, 32'hDEAD_BEEF);
    set_rd(5, 0);
    #1;
    n_cmp++;
    if (rd_data[0 +: XLEN] !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL bypass_x5: got %h want deadbeef", rd_data[0 +: XLEN]);
    end
    k = exp_read(5, 1'b0, v);
    n_cmp++;
    if (!k || rd_data_nb[0 +: XLEN] !== v) begin
      n_bad++; $display("FAIL nobypass_x5: got %h want %h", rd_data_nb[0 +: XLEN], v);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data[0 +: XLEN] !== 32'hDEAD_BEEF || rd_data_nb[0 +: XLEN] !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL stored_x5: got %h/%h want deadbeef", rd_data[0 +: XLEN], rd_data_nb[0 +: XLEN]);
    end
    drive_wr(1, 0, 32'h1234_5678);
    set_rd(0, 5);
    #1;
    n_cmp++;
    if (rd_data[0 +: XLEN] !== '0) begin
      n_bad++; $display("FAIL x0_bypass: got %h want 0", rd_data[0 +: XLEN]);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data[0 +: XLEN] !== '0 || rd_data_nb[0 +: XLEN] !== '0) begin
      n_bad++; $display("FAIL x0_stored: got %h/%h want 0", rd_data[0 +: XLEN], rd_data_nb[0 +: XLEN]);
    end
  endtask

  task automatic test_dual_write();
    logic [XLEN-1:0] old7;
    idle();
    old7 = m_mem[7];
    drive_wr(0, 7, 32'h0000_1111);
    drive_wr(1, 7, 32'h0000_2222);
    set_rd(7, 7);
    #1;
    n_cmp++;
    if (rd_data[0 +: XLEN] !== 32'h2222 || rd_data[XLEN +: XLEN] !== 32'h2222) begin
      n_bad++; $display("FAIL dual_bypass_x7: got %h/%h want 2222", rd_data[0 +: XLEN], rd_data[XLEN +: XLEN]);
    end
    n_cmp++;
    if (rd_data_nb[0 +: XLEN] !== old7) begin
      n_bad++; $display("FAIL dual_nobypass_x7: got %h want %h", rd_data_nb[0 +: XLEN], old7);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data[0 +: XLEN] !== 32'h2222 || rd_data_nb[XLEN +: XLEN] !== 32'h2222) begin
      n_bad++; $display("FAIL dual_stored_x7: got %h/%h want 2222", rd_data[0 +: XLEN], rd_data_nb[XLEN +: XLEN]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    set_rd(9, 0);
    sb_set  = 1'b1;
    sb_addr = AW'(9);
    #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL sb_no_forward: got %b want 0", rd_busy[0]);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL sb_set_x9: got %b want 1", rd_busy[0]);
    end
    drive_wr(0, 9, 32'hA5A5_0009);
    sb_set  = 1'b1;
    sb_addr = AW'(9);
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL sb_set_beats_clear: got %b want 1", rd_busy[0]);
    end
    drive_wr(1, 9, 32'h5A5A_0009);
    #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b1) begin
      n_bad++; $display("FAIL sb_clear_not_forwarded: got %b want 1", rd_busy[0]);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL sb_write_clears: got %b want 0", rd_busy[0]);
    end
    sb_set  = 1'b1;
    sb_addr = '0;
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_busy[1] !== 1'b0) begin
      n_bad++; $display("FAIL sb_x0_never_busy: got %b want 0", rd_busy[1]);
    end
  endtask

  task automatic test_clear();
    int cnt;
    idle();
    for (int a = 1; a < NREGS; a++) begin
      drive_wr(0, a, $urandom | 32'h1);
      sb_set  = 1'b1;
      sb_addr = AW'(a);
      tick();
    end
    idle();
    drive_wr(0, 4, 32'hCAFE_0004);
    sb_set  = 1'b1;
    sb_addr = AW'(6);
    clr_req = 1'b1;
    tick();
    idle();
    set_rd(3, 6);
    #1;
    n_cmp++;
    if (ready !== 1'b0 || rd_busy !== '0) begin
      n_bad++; $display("FAIL clear_entry: ready %b busy %b want ready 0 busy 0", ready, rd_busy);
    end
    wait_sweep(1'b1, cnt);
    n_cmp++;
    if (cnt != NREGS - 1 || m_sweeping) begin
      n_bad++; $display("FAIL clear_sweep_len: got %0d cycles want %0d", cnt, NREGS - 1);
    end
    for (int a = 0; a < NREGS; a += 2) begin
      set_rd(a, a + 1);
      #1;
      for (int p = 0; p < NRD; p++) begin
        n_cmp++;
        if (rd_data[p*XLEN +: XLEN] !== '0 || rd_data_nb[p*XLEN +: XLEN] !== '0 || rd_busy[p] !== 1'b0) begin
          n_bad++;
          $display("FAIL clear_zero x%0d: got %h/%h busy %b want 0/0 busy 0",
                   a + p, rd_data[p*XLEN +: XLEN], rd_data_nb[p*XLEN +: XLEN], rd_busy[p]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int              cnt;
    logic [XLEN-1:0] v;
    bit              k;
    idle();
    for (int a = 2; a <= 12; a++) begin
      drive_wr(0, a, 32'hB000_0000 | 32'(a));
      tick();
    end
    idle();
    clr_req = 1'b1;
    tick();
    idle();
    cnt = 0;
    while (m_pos != 10 && cnt < 50) begin
      tick();
      cnt++;
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (ready !== 1'b0 || rd_busy !== '0) begin
      n_bad++; $display("FAIL midsweep_reset: ready %b busy %b want 0/0", ready, rd_busy);
    end
    tick();
    rst_n = 1'b1;
    set_rd(11, 5);
    #1;
    k = exp_read(11, 1'b1, v);
    n_cmp++;
    if (!k || rd_data[0 +: XLEN] !== v || rd_data[XLEN +: XLEN] !== '0) begin
      n_bad++;
      $display("FAIL midsweep_contents: got x11=%h x5=%h want x11=%h x5=0",
               rd_data[0 +: XLEN], rd_data[XLEN +: XLEN], v);
    end
    wait_sweep(1'b0, cnt);
    n_cmp++;
    if (cnt != NREGS - 1 || m_sweeping) begin
      n_bad++; $display("FAIL midsweep_restart_len: got %0d cycles want %0d", cnt, NREGS - 1);
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] v;
    bit              k;
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int j = 0; j < NWR; j++) begin
        if ($urandom_range(0, 1) == 1) drive_wr(j, $urandom_range(0, 7), $urandom);
      end
      sb_set  = ($urandom_range(0, 3) == 0);
      sb_addr = AW'($urandom_range(0, 7));
      clr_req = ($urandom_range(0, 63) == 0);
      set_rd($urandom_range(0, 7), $urandom_range(0, NREGS - 1));
      if ($urandom_range(0, 2) == 0) rd_addr[0 +: AW] = wr_addr[AW +: AW];
      #1;
      n_cmp++;
      if (ready !== !m_sweeping || ready_nb !== !m_sweeping) begin
        n_bad++; $display("FAIL rand_ready c%0d: got %b/%b want %b", c, ready, ready_nb, !m_sweeping);
      end
      for (int p = 0; p < NRD; p++) begin
        int a;
        a = int'(rd_addr[p*AW +: AW]);
        k = exp_read(a, 1'b1, v);
        if (k) begin
          n_cmp++;
          if (rd_data[p*XLEN +: XLEN] !== v) begin
            n_bad++; $display("FAIL rand_bypass c%0d x%0d: got %h want %h", c, a, rd_data[p*XLEN +: XLEN], v);
          end
        end
        k = exp_read(a, 1'b0, v);
        if (k) begin
          n_cmp++;
          if (rd_data_nb[p*XLEN +: XLEN] !== v) begin
            n_bad++; $display("FAIL rand_nobypass c%0d x%0d: got %h want %h", c, a, rd_data_nb[p*XLEN +: XLEN], v);
          end
        end
        n_cmp++;
        if (rd_busy[p] !== m_busy[a] || rd_busy_nb[p] !== m_busy[a]) begin
          n_bad++; $display("FAIL rand_busy c%0d x%0d: got %b/%b want %b", c, a, rd_busy[p], rd_busy_nb[p], m_busy[a]);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    for (int a = 0; a < NREGS; a++) begin
      m_mem[a]   = '0;
      m_valid[a] = 1'b0;
    end
    rd_addr = '0;
    idle();
    test_reset();
    test_write_bypass();
    test_dual_write();
    test_scoreboard();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_regfile_mp
